vend_transaction_ctrl: RTL and testbench

//  Customer-side transaction front end, directly upstream of the store handler.
//  - Accumulates inserted coins into a credit register.
//  - On a product selection, queries the product table for price and stock.
//  - Checks stock and credit, then issues one buy request (mode 2'b01) with a handshake.
//  - Returns change, or refunds on cancel or inactivity timeout.

---
 rtl/vend_pkg.sv | 37 +++
 rtl/vend_idle_timer.sv | 34 +++
 rtl/vend_transaction_ctrl.sv | 159 +++++++++++++++
 tb/tb_vend_transaction_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// vend_pkg : shared FSM states, request modes and coin decode for the vending
//            transaction front end.  Rev 1.0
// ============================================================================
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOOKUP   = 3'd1,
    ST_CHECK    = 3'd2,
    ST_DISPENSE = 3'd3,
    ST_CHANGE   = 3'd4,
    ST_REFUND   = 3'd5
  } state_t;

  localparam logic [1:0] MODE_CHARGE = 2'b00;
  localparam logic [1:0] MODE_BUY    = 2'b01;
  localparam logic [1:0] MODE_PRICE  = 2'b10;

  localparam int NUM_PRODUCTS_DEF = 5;
  localparam int PRICE_W          = 4;
  localparam int COUNT_W          = 4;
  localparam int CODE_W           = 3;
  localparam int COIN_W           = 4;

  function automatic logic [COIN_W-1:0] coin_value(input logic [1:0] coin_type);
    case (coin_type)
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd5;
      default: return 4'd10;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vend_idle_timer.sv
`default_nettype none
// ============================================================================
// vend_idle_timer : idle-cycle counter, expire flags the TIMEOUT-th idle cycle.
//                   Rev 1.0
// ============================================================================
module vend_idle_timer #(
  parameter int TIMEOUT = 1000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int              CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = enable && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/vend_transaction_ctrl.sv
`default_nettype none
// ============================================================================
// vend_transaction_ctrl : coin credit, product check, buy handshake and
//                         change/refund front end.  Rev 1.0
// ============================================================================
module vend_transaction_ctrl
  import vend_pkg::*;
#(
  parameter int CREDIT_W     = 8,
  parameter int MAX_CREDIT   = 150,
  parameter int TIMEOUT      = 1000,
  parameter int NUM_PRODUCTS = NUM_PRODUCTS_DEF
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                sel_valid,
  input  logic [CODE_W-1:0]   sel_code,
  input  logic [COUNT_W-1:0]  sel_count,
  input  logic                cancel,
  output logic [CODE_W-1:0]   q_code,
  input  logic [PRICE_W-1:0]  q_price,
  input  logic [COUNT_W-1:0]  q_stock,
  output logic                buy_valid,
  output logic [1:0]          buy_mode,
  output logic [CODE_W-1:0]   buy_code,
  output logic [COUNT_W-1:0]  buy_count,
  input  logic                buy_ack,
  output logic                coin_reject,
  output logic                err_stock,
  output logic                err_credit,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic [CREDIT_W-1:0] credit
);

  localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W + 1)'(MAX_CREDIT);

  state_t                       state;
  logic [CODE_W-1:0]            code_r;
  logic [COUNT_W-1:0]           count_r;
  logic [CREDIT_W-1:0]          total_r;

  logic                         idle;
  logic [CREDIT_W:0]            coin_sum;
  logic                         coin_ok;
  logic                         take_cancel;
  logic                         take_sel;
  logic                         timeout;
  logic                         expire;
  logic [PRICE_W+COUNT_W-1:0]   prod;
  logic [CREDIT_W-1:0]          total_w;
  logic                         bad_stock;
  logic                         bad_credit;
  logic                         check_fail;

  assign idle        = (state == ST_IDLE);
  assign coin_sum    = {1'b0, credit} + (CREDIT_W + 1)'(coin_value(coin_type));
  // A coin arriving together with a cancel or a selection is always handed back.
  assign coin_ok     = idle && coin_valid && !cancel && !sel_valid && (coin_sum <= MAX_C);
  assign take_cancel = idle && cancel && (credit != '0);
  assign take_sel    = idle && sel_valid && !take_cancel;
  assign timeout     = expire && !take_cancel && !take_sel && !coin_ok;

  assign prod        = q_price * count_r;
  assign total_w     = CREDIT_W'(prod);
  assign bad_stock   = (int'(code_r) >= NUM_PRODUCTS) || (count_r == '0) || (q_stock < count_r);
  assign bad_credit  = (credit < total_w);
  assign check_fail  = (state == ST_CHECK) && (bad_stock || bad_credit);
  assign buy_mode    = MODE_BUY;

  vend_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (coin_ok || take_sel || check_fail),
    .enable  (idle && (credit != '0)),
    .expire  (expire)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      credit       <= '0;
      code_r       <= '0;
      count_r      <= '0;
      total_r      <= '0;
      q_code       <= '0;
      buy_valid    <= 1'b0;
      buy_code     <= '0;
      buy_count    <= '0;
      coin_reject  <= 1'b0;
      err_stock    <= 1'b0;
      err_credit   <= 1'b0;
      change_valid <= 1'b0;
      change_amt   <= '0;
    end else begin
      coin_reject  <= coin_valid && !coin_ok;
      err_stock    <= 1'b0;
      err_credit   <= 1'b0;
      change_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (coin_ok) credit <= coin_sum[CREDIT_W-1:0];
          if (take_cancel || timeout) begin
            state <= ST_REFUND;
          end else if (take_sel) begin
            code_r  <= sel_code;
            count_r <= sel_count;
            q_code  <= sel_code;
            state   <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: state <= ST_CHECK;
        ST_CHECK: begin
          total_r <= total_w;
          if (bad_stock) begin
            err_stock <= 1'b1;
            state     <= ST_IDLE;
          end else if (bad_credit) begin
            err_credit <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            buy_valid <= 1'b1;
            buy_code  <= code_r;
            buy_count <= count_r;
            state     <= ST_DISPENSE;
          end
        end
        ST_DISPENSE: begin
          if (buy_ack) begin
            buy_valid <= 1'b0;
            credit    <= credit - total_r;
            state     <= ST_CHANGE;
          end
        end
        ST_CHANGE: begin
          if (credit != '0) begin
            change_valid <= 1'b1;
            change_amt   <= credit;
            credit       <= '0;
          end
          state <= ST_IDLE;
        end
        ST_REFUND: begin
          change_valid <= 1'b1;
          change_amt   <= credit;
          credit       <= '0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vend_transaction_ctrl.sv
`default_nettype none
// ============================================================================
// tb_vend_transaction_ctrl : directed vectors, corner sequences and a random
//                            run against a timestamped transaction model.
// ============================================================================
module tb_vend_transaction_ctrl;

  localparam int TO   = 8;
  localparam int MAXC = 150;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_type = 2'b00;
  logic       sel_valid = 1'b0;
  logic [2:0] sel_code = 3'd0;
  logic [3:0] sel_count = 4'd0;
  logic       cancel = 1'b0;
  logic       buy_ack = 1'b0;
  logic [2:0] q_code;
  logic [3:0] q_price, q_stock;
  logic       buy_valid, coin_reject, err_stock, err_credit, change_valid;
  logic [1:0] buy_mode;
  logic [2:0] buy_code;
  logic [3:0] buy_count;
  logic [7:0] change_amt, credit;

  logic [3:0] price_tab [8] = '{4'd9, 4'd5, 4'd3, 4'd1, 4'd0, 4'd2, 4'd2, 4'd2};
  logic [3:0] stock_tab [8] = '{4'd15, 4'd3, 4'd9, 4'd1, 4'd15, 4'd15, 4'd15, 4'd15};
  int         coin_units [4] = '{1, 2, 5, 10};

  assign q_price = price_tab[q_code];
  assign q_stock = stock_tab[q_code];

  vend_transaction_ctrl #(
    .CREDIT_W(8), .MAX_CREDIT(MAXC), .TIMEOUT(TO), .NUM_PRODUCTS(5)
  ) dut (
    .clock(clock), .reset_n(reset_n), .coin_valid(coin_valid), .coin_type(coin_type),
    .sel_valid(sel_valid), .sel_code(sel_code), .sel_count(sel_count), .cancel(cancel),
    .q_code(q_code), .q_price(q_price), .q_stock(q_stock), .buy_valid(buy_valid),
    .buy_mode(buy_mode), .buy_code(buy_code), .buy_count(buy_count), .buy_ack(buy_ack),
    .coin_reject(coin_reject), .err_stock(err_stock), .err_credit(err_credit),
    .change_valid(change_valid), .change_amt(change_amt), .credit(credit)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0; buy_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic coin(input logic [1:0] t);
    coin_valid = 1'b1; coin_type = t;
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic sel(input int c, input int n);
    sel_valid = 1'b1; sel_code = 3'(c); sel_count = 4'(n);
    tick();
    sel_valid = 1'b0;
  endtask

  typedef struct {
    logic       cv;
    logic [1:0] ct;
    logic       cn;
    int         credit;
    logic       rej;
    logic       chg;
    int         amt;
  } vec_t;
  vec_t vecs [11];

  // Transaction model: every accepted action schedules its visible effects at
  // absolute cycle stamps; a ring holds effects that land 1-2 cycles later.
  int  k, idle_from, disp_from, bv_from;
  bit  disp, exp_bv;
  int  m_credit, quiet, m_total, m_code, m_count;
  bit  sch_cv [16];
  int  sch_amt [16];
  bit  sch_es [16];
  bit  sch_ec [16];
  bit  sch_zero [16];

  task automatic model_step(input bit c_v, input int c_units, input bit cn,
                            input bit sv, input int sc, input int sn, input bit ak);
    int s, n1, n2, total, e_amt;
    bit idle_now, coin_ok, e_cv, e_es, e_ec, e_rej, refund;
    s = k % 16; n1 = (k + 1) % 16; n2 = (k + 2) % 16;
    e_cv = sch_cv[s]; e_amt = sch_amt[s]; e_es = sch_es[s]; e_ec = sch_ec[s];
    if (sch_zero[s]) m_credit = 0;
    sch_cv[s] = 0; sch_es[s] = 0; sch_ec[s] = 0; sch_zero[s] = 0;
    if (disp && k == bv_from) exp_bv = 1;
    idle_now = !disp && (k >= idle_from);
    coin_ok  = idle_now && c_v && !cn && !sv && (m_credit + c_units <= MAXC);
    e_rej    = c_v && !coin_ok;
    refund   = 0;
    if (disp && k >= disp_from && ak) begin
      exp_bv = 0; disp = 0; m_credit -= m_total;
      if (m_credit > 0) begin sch_cv[n1] = 1; sch_amt[n1] = m_credit; end
      sch_zero[n1] = 1; idle_from = k + 2;
    end
    if (idle_now) begin
      if (cn && m_credit > 0) refund = 1;
      else if (sv) begin
        quiet = 0;
        total = int'(price_tab[sc]) * sn;
        if (sc >= 5 || sn == 0 || int'(stock_tab[sc]) < sn) begin
          sch_es[n2] = 1; idle_from = k + 3;
        end else if (m_credit < total) begin
          sch_ec[n2] = 1; idle_from = k + 3;
        end else begin
          disp = 1; bv_from = k + 2; disp_from = k + 3;
          m_total = total; m_code = sc; m_count = sn;
        end
      end else if (coin_ok) begin
        m_credit += c_units; quiet = 0;
      end else if (m_credit > 0) begin
        quiet++;
        if (quiet == TO) refund = 1;
      end else quiet = 0;
    end
    if (refund) begin
      sch_cv[n1] = 1; sch_amt[n1] = m_credit; sch_zero[n1] = 1;
      idle_from = k + 2; quiet = 0;
    end
    chk("rnd_credit", credit, m_credit);
    chk("rnd_coin_reject", coin_reject, e_rej);
    chk("rnd_err_stock", err_stock, e_es);
    chk("rnd_err_credit", err_credit, e_ec);
    chk("rnd_change_valid", change_valid, e_cv);
    if (e_cv) chk("rnd_change_amt", change_amt, e_amt);
    chk("rnd_buy_valid", buy_valid, exp_bv);
    if (exp_bv) begin
      chk("rnd_buy_code", buy_code, m_code);
      chk("rnd_buy_count", buy_count, m_count);
      chk("rnd_buy_mode", buy_mode, 1);
    end
    k++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, early;
    bit r_cv, r_cn, r_sv, r_ak;
    int r_ct, r_sc, r_sn;

    vecs[0]  = '{1'b1, 2'b00, 1'b0, 1,  1'b0, 1'b0, 0};
    vecs[1]  = '{1'b1, 2'b01, 1'b0, 3,  1'b0, 1'b0, 0};
    vecs[2]  = '{1'b1, 2'b10, 1'b0, 8,  1'b0, 1'b0, 0};
    vecs[3]  = '{1'b1, 2'b11, 1'b0, 18, 1'b0, 1'b0, 0};
    vecs[4]  = '{1'b0, 2'b00, 1'b0, 18, 1'b0, 1'b0, 0};
    vecs[5]  = '{1'b1, 2'b11, 1'b1, 18, 1'b1, 1'b0, 0};
    vecs[6]  = '{1'b1, 2'b00, 1'b0, 0,  1'b1, 1'b1, 18};
    vecs[7]  = '{1'b0, 2'b00, 1'b1, 0,  1'b0, 1'b0, 0};
    vecs[8]  = '{1'b1, 2'b10, 1'b1, 0,  1'b1, 1'b0, 0};
    vecs[9]  = '{1'b1, 2'b10, 1'b0, 5,  1'b0, 1'b0, 0};
    vecs[10] = '{1'b1, 2'b11, 1'b0, 15, 1'b0, 1'b0, 0};

    // Reset state
    idle_in();
    tick();
    chk("rst_credit", credit, 0);
    chk("rst_buy_valid", buy_valid, 0);
    chk("rst_change_valid", change_valid, 0);
    chk("rst_q_code", q_code, 0);
    reset_n = 1'b1;

    // Coin acceptance, cancel and refund vectors
    do_reset();
    for (int i = 0; i < 11; i++) begin
      coin_valid = vecs[i].cv; coin_type = vecs[i].ct; cancel = vecs[i].cn;
      tick();
      chk($sformatf("vec%0d_credit", i), credit, vecs[i].credit);
      chk($sformatf("vec%0d_coin_reject", i), coin_reject, vecs[i].rej);
      chk($sformatf("vec%0d_change_valid", i), change_valid, vecs[i].chg);
      if (vecs[i].chg) chk($sformatf("vec%0d_change_amt", i), change_amt, vecs[i].amt);
    end
    idle_in();

    // Purchase with change: 12 credit, 2 x 5 units
    do_reset();
    coin(2'b10); coin(2'b10); coin(2'b01);
    chk("t1_credit", credit, 12);
    sel(1, 2);
    chk("t1_q_code", q_code, 1);
    chk("t1_bv_c1", buy_valid, 0);
    tick(); chk("t1_bv_c2", buy_valid, 0);
    tick(); chk("t1_bv_c3", buy_valid, 1);
    chk("t1_buy_code", buy_code, 1);
    chk("t1_buy_count", buy_count, 2);
    chk("t1_buy_mode", buy_mode, 1);
    buy_ack = 1'b1; tick(); buy_ack = 1'b0;
    chk("t1_bv_after_ack", buy_valid, 0);
    chk("t1_credit_after_ack", credit, 2);
    tick();
    chk("t1_change_valid", change_valid, 1);
    chk("t1_change_amt", change_amt, 2);
    chk("t1_credit_final", credit, 0);
    tick(); chk("t1_change_pulse", change_valid, 0);

    // Credit ceiling
    do_reset();
    repeat (14) coin(2'b11);
    coin(2'b10);
    chk("t2_credit145", credit, 145);
    coin(2'b11);
    chk("t2_reject", coin_reject, 1);
    chk("t2_credit_kept", credit, 145);
    coin(2'b10);
    chk("t2_no_reject", coin_reject, 0);
    chk("t2_credit150", credit, 150);
    coin(2'b00);
    chk("t2_reject_at_max", coin_reject, 1);

    // Credit and stock errors
    do_reset();
    coin(2'b01); coin(2'b01);
    sel(2, 2); tick();
    chk("t3_ec_early", err_credit, 0);
    tick();
    chk("t3_err_credit", err_credit, 1);
    chk("t3_no_buy", buy_valid, 0);
    chk("t3_credit", credit, 4);
    sel(3, 2); tick(); tick();
    chk("t3_err_stock_qty", err_stock, 1);
    sel(5, 1); tick(); tick();
    chk("t3_err_stock_code", err_stock, 1);
    chk("t3_credit_kept", credit, 4);

    // Cancel with a simultaneous coin
    do_reset();
    coin(2'b10); coin(2'b01);
    cancel = 1'b1; coin_valid = 1'b1; coin_type = 2'b11;
    tick();
    idle_in();
    chk("t4_reject", coin_reject, 1);
    chk("t4_credit", credit, 7);
    tick();
    chk("t4_change_valid", change_valid, 1);
    chk("t4_change_amt", change_amt, 7);
    chk("t4_credit_zero", credit, 0);

    // Inactivity refund: REFUND entered TO cycles after the last coin, paid next cycle
    do_reset();
    coin(2'b00); coin(2'b01);
    early = 0;
    repeat (TO) begin tick(); if (change_valid) early++; end
    chk("t5_early_refund", early, 0);
    tick();
    chk("t5_change_valid", change_valid, 1);
    chk("t5_change_amt", change_amt, 3);
    chk("t5_credit_zero", credit, 0);
    early = 0;
    repeat (20) begin tick(); if (change_valid) early++; end
    chk("t5_no_refund_at_zero", early, 0);

    // Long ack wait, then asynchronous reset mid-dispense
    do_reset();
    coin(2'b11); coin(2'b11);
    sel(1, 3); tick(); tick();
    chk("t6_bv", buy_valid, 1);
    bad = 0;
    repeat (20) begin
      tick();
      if (!buy_valid || buy_code != 3'd1 || buy_count != 4'd3 || buy_mode != 2'b01 || credit != 8'd20)
        bad++;
    end
    chk("t6_stable", bad, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_bv", buy_valid, 0);
    chk("t6_rst_code", buy_code, 0);
    chk("t6_rst_count", buy_count, 0);
    chk("t6_rst_credit", credit, 0);
    chk("t6_rst_q_code", q_code, 0);
    buy_ack = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    buy_ack = 1'b0;
    chk("t6_post_bv", buy_valid, 0);
    chk("t6_post_credit", credit, 0);
    chk("t6_post_change", change_valid, 0);

    // Random run against the model
    do_reset();
    k = 0; idle_from = 0; disp = 0; exp_bv = 0; m_credit = 0; quiet = 0;
    m_total = 0; m_code = 0; m_count = 0; disp_from = 0; bv_from = 0;
    for (int i = 0; i < 16; i++) begin
      sch_cv[i] = 0; sch_amt[i] = 0; sch_es[i] = 0; sch_ec[i] = 0; sch_zero[i] = 0;
    end
    for (int i = 0; i < 3000; i++) begin
      r_cv = ($urandom % 100) < 35;
      r_ct = $urandom % 4;
      r_cn = ($urandom % 100) < 3;
      r_sv = ($urandom % 100) < 12;
      r_sc = $urandom % 8;
      r_sn = $urandom % 16;
      r_ak = ($urandom % 100) < 40;
      coin_valid = r_cv; coin_type = 2'(r_ct); cancel = r_cn;
      sel_valid = r_sv; sel_code = 3'(r_sc); sel_count = 4'(r_sn); buy_ack = r_ak;
      tick();
      model_step(r_cv, coin_units[r_ct], r_cn, r_sv, r_sc, r_sn, r_ak);
    end
    idle_in();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
